rhs_spi_responder: RTL
======================

// Module: rhs_spi_responder
// PURPOSE
//  SPI slave emulating the RHS2116 chip side of the RHS link: receives 32-bit commands on CS_b/SCLK/MOSI,
//  executes them against an internal register file and returns results on MISO with the chip's
//  two-frame pipeline latency. Sits opposite the RHS SPI master in the rhs_axi_tb design so
//  init/stim/Z-check sequences run closed-loop in simulation and on hardware without a headstage.
// PARAMETERS
//  SYNC_STAGES  2         synchronizer flops on cs_b/sclk/mosi (min 2)
//  CHIP_ID      16'h0020  read-only value of register 255
//  SAMPLE_BASE  16'h8000  CONVERT result base; sample = SAMPLE_BASE + {10'b0,chan} + frame_cnt[7:0]
// PORTS
//  aclk         in   1   system clock; every input sampled here
//  areset       in   1   synchronous, active-high reset
//  cs_b         in   1   SPI chip select, active low (async to aclk)
//  sclk         in   1   SPI clock, CPOL=0/CPHA=0 (async to aclk)
//  mosi         in   1   SPI data in, MSB first
//  miso         out  1   SPI data out, MSB first
//  frame_valid  out  1   1-cycle pulse: well-formed 32-bit frame decoded
//  frame_cmd    out  32  command word of last valid frame (held)
//  frame_err    out  1   1-cycle pulse: frame closed with bit count != 32
//  frame_cnt    out  16  valid frames since reset, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: miso=0, frame_valid=0, frame_err=0, frame_cmd=0, frame_cnt=0, all regs 0 except reg255=CHIP_ID,
//   result pipeline {res_n1,res_n2}=0, FSM IDLE. Reset mid-frame aborts the frame silently (no err pulse).
//  Inputs pass SYNC_STAGES flops, then one edge-detect flop; SCLK high/low >= SYNC_STAGES+1 aclk cycles.
//  FSM IDLE: cs_b falling edge -> SHIFT; load tx_sr=res_n2, bit_cnt=0, miso=tx_sr[31] next cycle.
//  SHIFT: sclk rising -> rx_sr={rx_sr[30:0],mosi}, bit_cnt+1 (saturates at 33);
//   sclk falling -> tx_sr<<1, miso=new tx_sr[31]; cs_b rising -> DONE.
//  DONE (1 cycle): bit_cnt==32 -> decode rx_sr, shift pipeline res_n2<=res_n1, res_n1<=result,
//   frame_cmd<=rx_sr, frame_valid=1, frame_cnt+1; else frame_err=1, pipeline/regs untouched. -> IDLE.
//  Pipeline: frame N's result is shifted out during frame N+2 (first two frames after reset return 0).
//  miso=0 whenever FSM in IDLE; sclk edges while cs_b high ignored.
//  Decode (cmd[31:30]): 00 CONVERT chan=cmd[21:16]: result={10'b0,chan,sample(16)};
//   10 WRITE addr=cmd[23:16], data=cmd[15:0]: reg[addr]<=data unless addr>=251; result={16'hFFFF,data};
//   11 READ addr=cmd[23:16]: result={16'h0000,reg[addr]} (value before this frame's write, none here);
//   01 CLEAR: result={16'h0000,16'h0000}; no register change.
//  Write to 251..255: ignored, still result={16'hFFFF,data} (matches chip).
//  Sample uses frame_cnt before increment; 16-bit addition wraps mod 2^16.
//  cs_b falling and rising in same aclk (glitch) -> treated as 0-bit frame -> frame_err.
// TESTING
//  1 Reset, READ reg255 (32'hC0FF0000) then two CLEAR -> 3rd frame miso = 32'h00000020; frames 1-2 miso=0.
//  2 WRITE 32'h80201234, CLEAR, READ 32'hC0200000, CLEAR, CLEAR -> frame3 miso=32'hFFFF1234, frame5 miso=32'h00001234.
//  3 WRITE 32'h80FBAAAA then READ reg251 -> result 0; write echo still 32'hFFFFAAAA.
//  4 CONVERT chan 17 (32'h00110000) as 1st frame after reset -> 3rd frame miso=32'h00118011 (base+17+0).
//  5 Frame of 31 SCLKs -> frame_err pulse, frame_cnt unchanged, next valid frame returns unshifted pipeline.
//  6 Assert areset mid-frame at bit 12 -> miso=0, no err, next frame returns 0, frame_cnt=0.

Source files
------------

// File: rtl/rhs_spi_responder.sv
// RHS2116-style SPI slave: decodes 32-bit commands against a local register file and
// returns each frame's result two frames later on MISO, as the real chip does.
module rhs_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] CHIP_ID     = 16'h0020,
  parameter logic [15:0] SAMPLE_BASE = 16'h8000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cs_b,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        frame_valid,
  output logic [31:0] frame_cmd,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
  logic                   r_cs_d, r_sclk_d;
  logic [31:0]            r_rx_sr, r_tx_sr;
  logic [5:0]             r_bit_cnt;
  logic [31:0]            r_res_n1, r_res_n2;
  logic [15:0]            r_regs [0:255];

  logic        w_cs, w_sclk, w_mosi;
  logic        w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
  logic [7:0]  w_addr;
  logic [5:0]  w_chan;
  logic [15:0] w_data, w_sample;
  logic [31:0] w_result;
  logic        w_wr_en;

  // cs_b synchronizer idles high so leaving reset never fakes a falling edge
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_d      <= 1'b1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_b};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_cs_d      <= w_cs;
      r_sclk_d    <= w_sclk;
    end
  end

  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_fall   = r_cs_d & ~w_cs;
  assign w_cs_rise   = ~r_cs_d & w_cs;
  assign w_sclk_rise = ~r_sclk_d & w_sclk;
  assign w_sclk_fall = r_sclk_d & ~w_sclk;

  always_comb begin
    w_addr   = r_rx_sr[23:16];
    w_data   = r_rx_sr[15:0];
    w_chan   = r_rx_sr[21:16];
    w_sample = SAMPLE_BASE + {10'b0, w_chan} + {8'b0, frame_cnt[7:0]};
    w_wr_en  = 1'b0;
    w_result = '0;
    case (r_rx_sr[31:30])
      2'b00: w_result = {10'b0, w_chan, w_sample};
      2'b10: begin
        w_result = {16'hFFFF, w_data};
        w_wr_en  = (w_addr < 8'd251);
      end
      2'b11: w_result = {16'h0000, r_regs[w_addr]};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= S_IDLE;
      miso        <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cmd   <= '0;
      frame_cnt   <= '0;
      r_rx_sr     <= '0;
      r_tx_sr     <= '0;
      r_bit_cnt   <= '0;
      r_res_n1    <= '0;
      r_res_n2    <= '0;
      for (int unsigned i = 0; i < 256; i++) r_regs[i] <= '0;
      r_regs[255] <= CHIP_ID;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          miso <= 1'b0;
          if (w_cs_fall) begin
            r_state   <= S_SHIFT;
            r_tx_sr   <= r_res_n2;
            r_bit_cnt <= '0;
            miso      <= r_res_n2[31];
          end
        end
        S_SHIFT: begin
          if (w_cs_rise) begin
            r_state <= S_DONE;
          end else begin
            if (w_sclk_rise) begin
              r_rx_sr <= {r_rx_sr[30:0], w_mosi};
              if (r_bit_cnt != 6'd33) r_bit_cnt <= r_bit_cnt + 6'd1;
            end
            if (w_sclk_fall) begin
              r_tx_sr <= {r_tx_sr[30:0], 1'b0};
              miso    <= r_tx_sr[30];
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          miso    <= 1'b0;
          if (r_bit_cnt == 6'd32) begin
            if (w_wr_en) r_regs[w_addr] <= w_data;
            r_res_n2    <= r_res_n1;
            r_res_n1    <= w_result;
            frame_cmd   <= r_rx_sr;
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
